// File: rtl/cl_ocl_mmio_pkg.sv
// Shared types and constants for the OCL MMIO bridge.
// The optional WAIT timeout is enabled with OCL_MMIO_BRIDGE_TIMEOUT_EN.
package cl_ocl_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_0BAD;

    // Map the register-bus error flag onto an AXI response code.
    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/cl_ocl_mmio_hold.sv
// One-entry valid/ready holding register for a single AXI-L channel.
// Ready is registered and is simply the complement of "entry occupied";
// the entry is released only when the owning transaction is issued.
module cl_ocl_mmio_hold #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clr,
    output logic             o_held,
    output logic [WIDTH-1:0] o_data
);

    logic             w_accept;
    logic             w_held_nxt;
    logic             r_held;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;

    // Handshake and next occupancy of the entry.
    always_comb begin
        w_accept   = i_valid & r_ready;
        w_held_nxt = (r_held & ~i_clr) | w_accept;
    end

    // Occupancy, registered ready and captured payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= {WIDTH{1'b0}};
        end else begin
            r_held  <= w_held_nxt;
            r_ready <= i_en & ~w_held_nxt;
            if (w_accept) begin
                r_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_held  = r_held;
    assign o_data  = r_data;

endmodule

// File: rtl/cl_ocl_mmio_bridge.sv
// AXI-Lite slave on the OCL channel, converting each AXI-L access into a
// single request on the CL register req/rsp bus, one transaction in flight.
// Define OCL_MMIO_BRIDGE_TIMEOUT_EN to force SLVERR after TIMEOUT_CYC
// cycles without a register response and to expose the sticky to_seen flag.
module cl_ocl_mmio_bridge
    import cl_ocl_mmio_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk_main_a0,
    input  logic                rst_main_n,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [1:0]          s_bresp,
    input  logic                s_arvalid,
    output logic                s_arready,
    input  logic [ADDR_W-1:0]   s_araddr,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                req_valid,
    input  logic                req_ready,
    output logic                req_wr,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [DATA_W-1:0]   req_wdata,
    output logic [DATA_W/8-1:0] req_wstrb,
    input  logic                rsp_valid,
    input  logic [DATA_W-1:0]   rsp_rdata,
    input  logic                rsp_err
`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
    , output logic              to_seen
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WH_W   = DATA_W + STRB_W;

    if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 65535)) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be within 2..65535");
    end

    state_t              r_state;
    logic                r_en;
    logic                r_is_wr;
    logic                r_prio_rd;
    logic                r_req_valid;
    logic                r_req_wr;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [STRB_W-1:0]   r_req_wstrb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [DATA_W-1:0]   r_rdata;
`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
    logic [15:0]         r_to_cnt;
    logic                r_to_seen;
`endif

    logic                w_aw_held;
    logic                w_w_held;
    logic                w_ar_held;
    logic [ADDR_W-1:0]   w_aw_data;
    logic [WH_W-1:0]     w_w_data;
    logic [ADDR_W-1:0]   w_ar_data;
    logic                w_wr_pend;
    logic                w_rd_pend;
    logic                w_pick_rd;
    logic                w_issue;
    logic                w_clr_wr;
    logic                w_clr_rd;

    // Readies stay low for one cycle after reset release, then track the holds.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_en <= 1'b0;
        end else begin
            r_en <= 1'b1;
        end
    end

    cl_ocl_mmio_hold #(.WIDTH(ADDR_W)) u_aw_hold (
        .clk(clk_main_a0), .rst_n(rst_main_n), .i_en(r_en),
        .i_valid(s_awvalid), .o_ready(s_awready), .i_data(s_awaddr),
        .i_clr(w_clr_wr), .o_held(w_aw_held), .o_data(w_aw_data)
    );

    cl_ocl_mmio_hold #(.WIDTH(WH_W)) u_w_hold (
        .clk(clk_main_a0), .rst_n(rst_main_n), .i_en(r_en),
        .i_valid(s_wvalid), .o_ready(s_wready), .i_data({s_wstrb, s_wdata}),
        .i_clr(w_clr_wr), .o_held(w_w_held), .o_data(w_w_data)
    );

    cl_ocl_mmio_hold #(.WIDTH(ADDR_W)) u_ar_hold (
        .clk(clk_main_a0), .rst_n(rst_main_n), .i_en(r_en),
        .i_valid(s_arvalid), .o_ready(s_arready), .i_data(s_araddr),
        .i_clr(w_clr_rd), .o_held(w_ar_held), .o_data(w_ar_data)
    );

    // Pending detection, arbitration pick and hold release on request accept.
    always_comb begin
        w_wr_pend = w_aw_held & w_w_held;
        w_rd_pend = w_ar_held;
        w_issue   = w_wr_pend | w_rd_pend;
        if (w_wr_pend && w_rd_pend) begin
            w_pick_rd = r_prio_rd;
        end else begin
            w_pick_rd = w_rd_pend;
        end
        w_clr_wr = (r_state == REQ) & req_ready & r_is_wr;
        w_clr_rd = (r_state == REQ) & req_ready & ~r_is_wr;
    end

    // Transaction FSM with all bus-facing outputs registered.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_state     <= IDLE;
            r_is_wr     <= 1'b0;
            r_prio_rd   <= 1'b1;
            r_req_valid <= 1'b0;
            r_req_wr    <= 1'b0;
            r_req_addr  <= {ADDR_W{1'b0}};
            r_req_wdata <= {DATA_W{1'b0}};
            r_req_wstrb <= {STRB_W{1'b0}};
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_rvalid    <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= {DATA_W{1'b0}};
`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
            r_to_cnt    <= 16'd0;
            r_to_seen   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        if (w_wr_pend && w_rd_pend) begin
                            r_prio_rd <= ~w_pick_rd;
                        end
                        r_is_wr     <= ~w_pick_rd;
                        r_req_valid <= 1'b1;
                        r_req_wr    <= ~w_pick_rd;
                        r_req_addr  <= w_pick_rd ? w_ar_data : w_aw_data;
                        r_req_wdata <= w_pick_rd ? {DATA_W{1'b0}} : w_w_data[DATA_W-1:0];
                        r_req_wstrb <= w_pick_rd ? {STRB_W{1'b0}} : w_w_data[WH_W-1:DATA_W];
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_req_wr    <= 1'b0;
                        r_req_addr  <= {ADDR_W{1'b0}};
                        r_req_wdata <= {DATA_W{1'b0}};
                        r_req_wstrb <= {STRB_W{1'b0}};
`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
                        r_to_cnt    <= 16'd0;
`endif
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        if (r_is_wr) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= resp_of(rsp_err);
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= resp_of(rsp_err);
                            r_rdata  <= rsp_rdata;
                        end
                        r_state <= RESP;
                    end
`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
                    else if (r_to_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        if (r_is_wr) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_SLVERR;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= RESP_SLVERR;
                            r_rdata  <= DATA_W'(TIMEOUT_RDATA);
                        end
                        r_to_seen <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (r_is_wr && s_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end else if (!r_is_wr && s_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_rvalid  = r_rvalid;
    assign s_rresp   = r_rresp;
    assign s_rdata   = r_rdata;
    assign req_valid = r_req_valid;
    assign req_wr    = r_req_wr;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign req_wstrb = r_req_wstrb;
`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
    assign to_seen   = r_to_seen;
`endif

endmodule

// File: tb/tb_cl_ocl_mmio_bridge.sv
// Directed self-checking bench for cl_ocl_mmio_bridge.
// Build with OCL_MMIO_BRIDGE_TIMEOUT_EN defined to also cover the timeout path.
module tb_cl_ocl_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        req_valid, req_ready, req_wr, rsp_valid, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;
`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
    logic        to_seen;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cl_ocl_mmio_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
        , .to_seen(to_seen)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        int n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_valid"}, 64'(req_valid), 64'd1);
        chk({tag, "_req_fields"}, {27'd0, req_wr, req_addr, req_wstrb},
            {27'd0, wr, addr, wstrb});
        chk({tag, "_req_wdata"}, 64'(req_wdata), 64'(wdata));
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk({tag, "_req_drop"}, 64'(req_valid), 64'd0);
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        rsp_rdata = rdata;
        rsp_err   = err;
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic finish_wr(input string tag, input logic [1:0] resp);
        chk({tag, "_bvalid"}, 64'(s_bvalid), 64'd1);
        chk({tag, "_bresp"}, 64'(s_bresp), 64'(resp));
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk({tag, "_bdone"}, 64'(s_bvalid), 64'd0);
    endtask

    task automatic finish_rd(input string tag, input logic [31:0] rdata, input logic [1:0] resp);
        chk({tag, "_rvalid"}, 64'(s_rvalid), 64'd1);
        chk({tag, "_rdata_rresp"}, {30'd0, s_rresp, s_rdata}, {30'd0, resp, rdata});
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk({tag, "_rdone"}, 64'(s_rvalid), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b0; s_rready = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] t_ready;
        int n;
        rst_n = 1'b0;
        s_awvalid = 1'b0; s_awaddr = 32'd0; s_wvalid = 1'b0; s_wdata = 32'd0; s_wstrb = 4'd0;
        s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = 32'd0; s_rready = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'd0; rsp_err = 1'b0;
        tick();
        tick();
        // Reset values
        chk("reset_ctrl", {56'd0, s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                           req_valid, req_wr, 1'b0}, 64'd0);
        chk("reset_resp", {30'd0, s_bresp, s_rresp, s_rdata}, 64'd0);
        chk("reset_req", {28'd0, req_wstrb, req_addr}, 64'd0);
        chk("reset_wdata", 64'(req_wdata), 64'd0);
`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
        chk("reset_to_seen", 64'(to_seen), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ready_edge1", 64'({s_awready, s_wready, s_arready}), 64'd0);
        tick();
        chk("ready_edge2", 64'({s_awready, s_wready, s_arready}), 64'd7);

        // 1: AW and W together
        s_awvalid = 1'b1; s_awaddr = 32'h0000_0500;
        s_wvalid = 1'b1; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("t1_ready_low", 64'({s_awready, s_wready}), 64'd0);
        wait_req("t1", 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 4'hF);
        respond(32'h0, 1'b0);
        finish_wr("t1", 2'b00);

        // 2: W three cycles ahead of AW
        s_wvalid = 1'b1; s_wdata = 32'h0000_1234; s_wstrb = 4'hF;
        tick();
        s_wvalid = 1'b0;
        chk("t2_wready_low", 64'({s_wready, s_awready}), 64'd1);
        tick();
        chk("t2_no_req_a", 64'(req_valid), 64'd0);
        tick();
        chk("t2_no_req_b", 64'({req_valid, s_wready}), 64'd0);
        s_awvalid = 1'b1; s_awaddr = 32'h0000_0504;
        tick();
        s_awvalid = 1'b0;
        wait_req("t2", 1'b1, 32'h0000_0504, 32'h0000_1234, 4'hF);
        respond(32'h0, 1'b0);
        finish_wr("t2", 2'b00);
        tick();
        tick();
        chk("t2_single", 64'({s_bvalid, req_valid}), 64'd0);

        // 3: read and write pending together, alternating priority
        do_reset();
        for (int p = 0; p < 3; p++) begin
            t_ready = {1'b0, s_awready, s_wready, s_arready};
            chk($sformatf("t3_p%0d_ready", p), 64'(t_ready), 64'd7);
            s_arvalid = 1'b1; s_araddr = 32'h0000_0508;
            s_awvalid = 1'b1; s_awaddr = 32'h0000_050C;
            s_wvalid = 1'b1; s_wdata = 32'h5050_0000 + 32'(p); s_wstrb = 4'h3;
            tick();
            s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if ((k == 0) == (p % 2 == 0)) begin
                    wait_req($sformatf("t3_p%0d_rd", p), 1'b0, 32'h0000_0508, 32'h0, 4'h0);
                    respond(32'hA000_0000 + 32'(p), 1'b0);
                    finish_rd($sformatf("t3_p%0d_rd", p), 32'hA000_0000 + 32'(p), 2'b00);
                end else begin
                    wait_req($sformatf("t3_p%0d_wr", p), 1'b1, 32'h0000_050C,
                             32'h5050_0000 + 32'(p), 4'h3);
                    respond(32'h0, 1'b0);
                    finish_wr($sformatf("t3_p%0d_wr", p), 2'b00);
                end
            end
        end

        // 4: minimum latency read with error, rready held off
        req_ready = 1'b1;
        s_arvalid = 1'b1; s_araddr = 32'h0000_0510;
        tick();
        s_arvalid = 1'b0;
        chk("t4_edge0_req", 64'(req_valid), 64'd0);
        tick();
        chk("t4_edge1_req", {31'd0, req_valid, req_addr}, {31'd0, 1'b1, 32'h0000_0510});
        tick();
        req_ready = 1'b0;
        chk("t4_edge2", 64'({req_valid, s_rvalid}), 64'd0);
        rsp_valid = 1'b1; rsp_rdata = 32'h0BAD_F00D; rsp_err = 1'b1;
        tick();
        rsp_valid = 1'b0; rsp_err = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4_hold_c%0d", c), {29'd0, s_rvalid, s_rresp, s_rdata},
                {29'd0, 1'b1, 2'b10, 32'h0BAD_F00D});
            tick();
        end
        finish_rd("t4", 32'h0BAD_F00D, 2'b10);

        // Response outside WAIT is dropped
        rsp_valid = 1'b1; rsp_rdata = 32'h1111_2222;
        tick();
        rsp_valid = 1'b0;
        tick();
        chk("stray_rsp", 64'({s_bvalid, s_rvalid, req_valid}), 64'd0);

`ifdef OCL_MMIO_BRIDGE_TIMEOUT_EN
        // 5: timeout after 8 WAIT cycles
        s_arvalid = 1'b1; s_araddr = 32'h0000_0520;
        tick();
        s_arvalid = 1'b0;
        wait_req("t5", 1'b0, 32'h0000_0520, 32'h0, 4'h0);
        n = 0;
        while (!s_rvalid && n < 30) begin
            tick();
            n++;
        end
        chk("t5_cycles", 64'(n), 64'd8);
        chk("t5_resp", {29'd0, to_seen, s_rresp, s_rdata}, {29'd0, 1'b1, 2'b10, 32'hDEAD_0BAD});
        rsp_valid = 1'b1; rsp_rdata = 32'h7777_7777;
        tick();
        rsp_valid = 1'b0;
        finish_rd("t5", 32'hDEAD_0BAD, 2'b10);
        tick();
        chk("t5_after", 64'({s_rvalid, to_seen}), 64'd1);
`endif

        // 6: reset during WAIT with a W held
        s_arvalid = 1'b1; s_araddr = 32'h0000_0518;
        tick();
        s_arvalid = 1'b0;
        wait_req("t6", 1'b0, 32'h0000_0518, 32'h0, 4'h0);
        s_wvalid = 1'b1; s_wdata = 32'h9999_0000; s_wstrb = 4'hF;
        tick();
        s_wvalid = 1'b0;
        chk("t6_w_held", 64'(s_wready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_zero", 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, req_valid}),
            64'd0);
        chk("t6_async_req", {28'd0, req_wstrb, req_addr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("t6_ready_back", 64'({s_awready, s_wready, s_arready}), 64'd7);
        s_arvalid = 1'b1; s_araddr = 32'h0000_051C;
        tick();
        s_arvalid = 1'b0;
        wait_req("t6_post", 1'b0, 32'h0000_051C, 32'h0, 4'h0);
        respond(32'h600D_CAFE, 1'b0);
        finish_rd("t6_post", 32'h600D_CAFE, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
